// File: rtl/tdp_bram36k_responder.sv
// True-dual-port 36K BRAM responder: per-lane writes, read-first ports, post-reset clear
// sequencer and cross-port collision pulse. Define BRAM_RD_OUT_REG_EN for 2-cycle read latency.
module tdp_bram36k_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 36,
  parameter int BE_WIDTH   = 4
) (
  input  logic                  CLK_i,
  input  logic                  RESET_N_i,
  input  logic                  PORT_A_WEN_i,
  input  logic [BE_WIDTH-1:0]   PORT_A_WR_BE_i,
  input  logic                  PORT_A_REN_i,
  input  logic [ADDR_WIDTH-1:0] PORT_A_ADDR_i,
  input  logic [DATA_WIDTH-1:0] PORT_A_WR_DATA_i,
  output logic [DATA_WIDTH-1:0] PORT_A_RD_DATA_o,
  input  logic                  PORT_B_WEN_i,
  input  logic [BE_WIDTH-1:0]   PORT_B_WR_BE_i,
  input  logic                  PORT_B_REN_i,
  input  logic [ADDR_WIDTH-1:0] PORT_B_ADDR_i,
  input  logic [DATA_WIDTH-1:0] PORT_B_WR_DATA_i,
  output logic [DATA_WIDTH-1:0] PORT_B_RD_DATA_o,
  output logic                  BUSY_o,
  output logic                  COLLISION_o
);

  localparam int LANE_WIDTH = DATA_WIDTH / BE_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   rd_a;
  logic [DATA_WIDTH-1:0]   rd_b;
  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

  logic same_addr;
  logic ww_conflict;
  logic rw_conflict;

  assign same_addr   = (PORT_A_ADDR_i == PORT_B_ADDR_i);
  assign ww_conflict = PORT_A_WEN_i & PORT_B_WEN_i & (|(PORT_A_WR_BE_i & PORT_B_WR_BE_i));
  assign rw_conflict = (PORT_A_WEN_i & PORT_B_REN_i) | (PORT_B_WEN_i & PORT_A_REN_i);

  // Control FSM with registered status outputs and read registers.
  always_ff @(posedge CLK_i or negedge RESET_N_i) begin
    if (!RESET_N_i) begin
      state       <= CLEAR;
      clr_cnt     <= '0;
      BUSY_o      <= 1'b1;
      COLLISION_o <= 1'b0;
      rd_a        <= '0;
      rd_b        <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt     <= clr_cnt + 1'b1;
          COLLISION_o <= 1'b0;
          rd_a        <= '0;
          rd_b        <= '0;
          if (clr_cnt == LAST_ADDR) begin
            state  <= READY;
            BUSY_o <= 1'b0;
          end
        end
        READY: begin
          COLLISION_o <= same_addr & (ww_conflict | rw_conflict);
          // NOTE: non-blocking memory updates make these reads see pre-write data (read-first).
          if (PORT_A_REN_i) rd_a <= mem[PORT_A_ADDR_i];
          if (PORT_B_REN_i) rd_b <= mem[PORT_B_ADDR_i];
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // NOTE: the array has no reset; the clear sequencer zeroes it after every reset instead.
  // Port B lanes are written first so a same-lane, same-address port A write overrides them.
  always_ff @(posedge CLK_i) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (PORT_B_WEN_i && PORT_B_WR_BE_i[i])
          mem[PORT_B_ADDR_i][i*LANE_WIDTH +: LANE_WIDTH] <= PORT_B_WR_DATA_i[i*LANE_WIDTH +: LANE_WIDTH];
        if (PORT_A_WEN_i && PORT_A_WR_BE_i[i])
          mem[PORT_A_ADDR_i][i*LANE_WIDTH +: LANE_WIDTH] <= PORT_A_WR_DATA_i[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

`ifdef BRAM_RD_OUT_REG_EN
  logic [DATA_WIDTH-1:0] out_a;
  logic [DATA_WIDTH-1:0] out_b;

  always_ff @(posedge CLK_i or negedge RESET_N_i) begin
    if (!RESET_N_i) begin
      out_a <= '0;
      out_b <= '0;
    end else begin
      out_a <= rd_a;
      out_b <= rd_b;
    end
  end

  assign PORT_A_RD_DATA_o = out_a;
  assign PORT_B_RD_DATA_o = out_b;
`else
  assign PORT_A_RD_DATA_o = rd_a;
  assign PORT_B_RD_DATA_o = rd_b;
`endif

endmodule
